uart_rx_fe: RTL and testbench

- UART receive front-end for the RV32I single-cycle SoC.
- Sits between the `UART_rx` pad and the core's memory-mapped UART register block, which it feeds.
- Synchronises the asynchronous serial line and decodes 8N1 frames using 16x oversampling.
- Presents each received byte through a one-entry valid/ready holding register, with sticky framing and overrun status.

---
 rtl/uart_rx_fe_if.sv | 11 +
 rtl/uart_rx_fe.sv | 146 ++++++++++++++
 tb/tb_uart_rx_fe.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fe_if.sv
// Received-byte handshake between the UART receive front-end and its consumer.
interface uart_rx_fe_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fe.sv
// UART 8N1 receive front-end: 2-flop synchroniser, oversampled frame decoder,
// one-entry valid/ready holding register and sticky framing/overrun flags.
module uart_rx_fe #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_in,
    input  logic        err_clr,
    output logic        frame_err,
    output logic        overrun,
    output logic [1:0]  rx_state,
    uart_rx_fe_if.master rx
);

    localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SAMP_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W   = $clog2(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rx_s;
    logic                 armed;
    logic [DIV_W-1:0]     div_cnt;
    logic [SAMP_W-1:0]    samp_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;

    logic tick;
    logic start_mid;
    logic bit_mid;
    logic stop_good;
    logic stop_bad;
    logic accept;
    logic load;
    logic ovr_set;

    // Tick phase restarts at start-bit detection because the divider idles at 0.
    assign tick      = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));
    assign start_mid = tick && (samp_cnt == SAMP_W'(OVERSAMPLE / 2 - 1));
    assign bit_mid   = tick && (samp_cnt == SAMP_W'(OVERSAMPLE - 1));
    assign stop_good = (state == STOP) && bit_mid && rx_s;
    assign stop_bad  = (state == STOP) && bit_mid && !rx_s;
    assign accept    = rx.rx_valid && rx.rx_ready;
    assign load      = stop_good && (!rx.rx_valid || rx.rx_ready);
    assign ovr_set   = stop_good && rx.rx_valid && !rx.rx_ready;
    assign rx_state  = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: synchroniser flops reset to the idle line level (1) so that
            // leaving reset never looks like a start bit.
            sync1       <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            armed       <= 1'b1;
            div_cnt     <= '0;
            samp_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rx.rx_data  <= '0;
            rx.rx_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every term above
            // reads the pre-edge value of the state it depends on.
            sync1 <= rx_in;
            rx_s  <= sync1;

            if (state == IDLE || tick) div_cnt <= '0;
            else                       div_cnt <= div_cnt + 1'b1;

            if (load) begin
                rx.rx_data  <= shift;
                rx.rx_valid <= 1'b1;
            end else if (accept) begin
                rx.rx_valid <= 1'b0;
            end

            // A new error event wins over a coincident clear.
            if (stop_bad)     frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
            if (ovr_set)      overrun   <= 1'b1;
            else if (err_clr) overrun   <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        samp_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (start_mid) begin
                        samp_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= rx_s ? IDLE : DATA;
                    end else if (tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_mid) begin
                        samp_cnt <= '0;
                        shift    <= {rx_s, shift[DATA_BITS-1:1]};
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_mid) begin
                        samp_cnt <= '0;
                        state    <= IDLE;
                        // A low stop bit may be a break; wait for the line to rise.
                        if (!rx_s) armed <= 1'b0;
                    end else if (tick) begin
                        samp_cnt <= samp_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fe.sv
// Scoreboard bench for uart_rx_fe: directed frames queue expected bytes,
// a negedge monitor pops and compares each byte the DUT presents.
module tb_uart_rx_fe;

    localparam int CLK_FREQ = 3_200_000;
    localparam int BAUD     = 100_000;
    localparam int OS       = 16;
    localparam int DB       = 8;
    localparam int BIT_CLK  = 32;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       rx_in   = 1'b1;
    logic       err_clr = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic [1:0] rx_state;

    uart_rx_fe_if #(.DATA_BITS(DB)) rx_bus ();

    uart_rx_fe #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD),
        .OVERSAMPLE(OS),
        .DATA_BITS (DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .err_clr  (err_clr),
        .frame_err(frame_err),
        .overrun  (overrun),
        .rx_state (rx_state),
        .rx       (rx_bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard and monitor
    logic [7:0] exp_q[$];
    logic [7:0] held;
    logic [7:0] exp_byte;
    logic       valid_prev  = 1'b0;
    logic       acc_prev    = 1'b0;
    logic [3:0] visited     = '0;
    int         cyc         = 0;
    int         valid_cycles = 0;
    int         present_cyc = 0;
    int         start_cyc   = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        visited[rx_state] = 1'b1;
        if (rx_bus.rx_valid) valid_cycles++;
        if (rx_bus.rx_valid && (!valid_prev || acc_prev)) begin
            present_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_bus.rx_data);
            end else begin
                exp_byte = exp_q.pop_front();
                check("rx_data", {24'd0, rx_bus.rx_data}, {24'd0, exp_byte});
            end
            held = rx_bus.rx_data;
        end else if (rx_bus.rx_valid && valid_prev) begin
            check("rx_data_stable", {24'd0, rx_bus.rx_data}, {24'd0, held});
        end
        valid_prev = rx_bus.rx_valid;
        acc_prev   = rx_bus.rx_valid && rx_bus.rx_ready;
    end

    // Stimulus helpers: all input changes land 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx_in = v;
        idle(n);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_lvl, input bit expect_it);
        if (expect_it) exp_q.push_back(b);
        start_cyc = cyc;
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_CLK);
        drive_bit(stop_lvl, BIT_CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int lat;
        rx_bus.rx_ready = 1'b0;
        #2 rst = 1'b0;
        idle(3);
        check("reset_valid", {31'd0, rx_bus.rx_valid}, 0);
        check("reset_data", {24'd0, rx_bus.rx_data}, 0);
        check("reset_state", {30'd0, rx_state}, 0);
        check("reset_flags", {30'd0, frame_err, overrun}, 0);
        rst = 1'b1;
        idle(5);

        // Clean frame 0xA5, consumer not ready
        visited = '0;
        send_byte(8'hA5, 1'b1, 1'b1);
        idle(4);
        lat = present_cyc - start_cyc;
        check("t1_valid", {31'd0, rx_bus.rx_valid}, 1);
        check("t1_latency_304_to_310", {31'd0, (lat >= 304 && lat <= 310)}, 1);
        check("t1_states_visited", {28'd0, visited}, 4'hF);
        check("t1_flags", {30'd0, frame_err, overrun}, 0);
        rx_bus.rx_ready = 1'b1;
        idle(1);
        rx_bus.rx_ready = 1'b0;
        check("t1_drained", {31'd0, rx_bus.rx_valid}, 0);

        // 10-clk glitch: START entered, rejected at mid-bit
        idle(4);
        visited = '0;
        drive_bit(1'b0, 10);
        drive_bit(1'b1, 60);
        check("t2_visited_idle_start_only", {28'd0, visited}, 4'b0011);
        check("t2_state", {30'd0, rx_state}, 0);
        check("t2_valid", {31'd0, rx_bus.rx_valid}, 0);
        check("t2_flags", {30'd0, frame_err, overrun}, 0);

        // Overrun: 0x3C held, 0x81 dropped
        send_byte(8'h3C, 1'b1, 1'b1);
        send_byte(8'h81, 1'b1, 1'b0);
        idle(4);
        check("t3_data_kept", {24'd0, rx_bus.rx_data}, 8'h3C);
        check("t3_valid", {31'd0, rx_bus.rx_valid}, 1);
        check("t3_overrun", {31'd0, overrun}, 1);
        check("t3_frame_err", {31'd0, frame_err}, 0);
        rx_bus.rx_ready = 1'b1;
        idle(1);
        rx_bus.rx_ready = 1'b0;
        check("t3_drained", {31'd0, rx_bus.rx_valid}, 0);
        check("t3_overrun_sticky", {31'd0, overrun}, 1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("t3_overrun_cleared", {31'd0, overrun}, 0);

        // Back-to-back with consumer always ready
        rx_bus.rx_ready = 1'b1;
        idle(4);
        valid_cycles = 0;
        send_byte(8'h01, 1'b1, 1'b1);
        send_byte(8'h02, 1'b1, 1'b1);
        idle(4);
        check("t4_valid_cycles", valid_cycles, 2);
        check("t4_overrun", {31'd0, overrun}, 0);
        check("t4_valid_low", {31'd0, rx_bus.rx_valid}, 0);
        rx_bus.rx_ready = 1'b0;

        // Framing error followed by a break held for 20 bit times
        send_byte(8'h55, 1'b0, 1'b0);
        bad = 0;
        for (int i = 0; i < 20 * BIT_CLK; i++) begin
            idle(1);
            if (rx_state != 2'd0) bad++;
        end
        check("t5_no_retrigger_in_break", bad, 0);
        check("t5_frame_err", {31'd0, frame_err}, 1);
        check("t5_valid", {31'd0, rx_bus.rx_valid}, 0);
        check("t5_overrun", {31'd0, overrun}, 0);
        drive_bit(1'b1, 64);
        send_byte(8'h12, 1'b1, 1'b1);
        idle(4);
        check("t5_valid_after_break", {31'd0, rx_bus.rx_valid}, 1);
        check("t5_frame_err_sticky", {31'd0, frame_err}, 1);

        // Asynchronous reset in the middle of frame 0xFF
        fork
            send_byte(8'hFF, 1'b1, 1'b0);
            begin
                idle(150);
                check("t6_in_data", {30'd0, rx_state}, 2);
                @(negedge clk);
                #3 rst = 1'b0;
                #1;
                check("t6_rst_valid", {31'd0, rx_bus.rx_valid}, 0);
                check("t6_rst_data", {24'd0, rx_bus.rx_data}, 0);
                check("t6_rst_flags", {30'd0, frame_err, overrun}, 0);
                check("t6_rst_state", {30'd0, rx_state}, 0);
            end
        join
        check("t6_state_held", {30'd0, rx_state}, 0);
        rst = 1'b1;
        idle(10);
        send_byte(8'h7E, 1'b1, 1'b1);
        idle(4);
        check("t6_valid", {31'd0, rx_bus.rx_valid}, 1);
        check("t6_data", {24'd0, rx_bus.rx_data}, 8'h7E);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
